pll_drp_ctrl: RTL
=================

PLL_DRP_CTRL -- requirements
Module: pll_drp_ctrl

Interface
REQ-001 Parameter RD_LAT, default 2: cycles from the read opcode cycle to valid pll_mdrdo.
REQ-002 Parameter RST_CYCLES, default 16: pll_reset pulse length in clk cycles.
REQ-003 Parameter LOCK_TIMEOUT, default 65535: maximum clk cycles to wait for lock.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  reset.
REQ-005 req_valid  in  1  request offered; req_ready  out  1  request accepted when both are high.
REQ-006 req_write  in  1  1 = write burst, 0 = read burst; req_addr  in  8  start register address.
REQ-007 req_len  in  4  beats minus 1; req_relock  in  1  pulse PLL reset and await lock after the burst.
REQ-008 wr_data  in  8  write beat data; wr_valid  in  1  beat offered; wr_ready  out  1  beat consumed.
REQ-009 rd_data  out  8  read beat data; rd_valid  out  1  one-cycle strobe, no backpressure.
REQ-010 busy  out  1  not IDLE; done  out  1  one-cycle completion pulse; err  out  1  sticky lock timeout.
REQ-011 pll_mdopc  out  2  opcode; pll_mdainc  out  1  address auto-increment; pll_mdwdi  out  8  address/data.
REQ-012 pll_mdrdo  in  8  PLL read data; pll_reset  out  1  PLL reset; pll_lock  in  1  PLL lock, asynchronous.

Function
REQ-013 Opcodes SHALL be: 00 NOP, 11 load address (pll_mdwdi = address), 01 write (pll_mdwdi = data), 10 read.
REQ-014 States SHALL be: IDLE, ADDR, WBEAT, RCMD, RWAIT, PRST, WLOCK, DONE.
REQ-015 req_ready SHALL be high only in IDLE; acceptance latches write, addr, len and relock, clears err, and enters ADDR.
REQ-016 ADDR SHALL last exactly one cycle with opcode 11 and pll_mdwdi = req_addr, then go to WBEAT (write) or RCMD (read).
REQ-017 WBEAT SHALL hold NOP until wr_valid; in the cycle wr_valid is high it SHALL drive opcode 01, pll_mdwdi = wr_data, and wr_ready = 1.
REQ-018 RCMD SHALL last one cycle with opcode 10; RWAIT SHALL capture pll_mdrdo into rd_data exactly RD_LAT cycles after the opcode cycle, with rd_valid high that cycle only.
REQ-019 pll_mdainc SHALL be 1 in a write or read opcode cycle iff further beats remain; it SHALL be 0 on the last beat and in every other cycle.
REQ-020 The burst SHALL be len+1 beats; req_len = 15 gives 16 beats, with no wrap.
REQ-021 After the last beat, relock = 1 SHALL go to PRST; relock = 0 SHALL go to DONE.
REQ-022 PRST SHALL hold pll_reset = 1 for exactly RST_CYCLES cycles, then enter WLOCK with pll_reset = 0.
REQ-023 WLOCK SHALL exit to DONE on synchronised lock = 1; after LOCK_TIMEOUT cycles without lock it SHALL set err and exit to DONE.
REQ-024 DONE SHALL last one cycle with done = 1, then return to IDLE.
REQ-025 pll_mdopc SHALL be 00 in every cycle not named above.
REQ-026 pll_lock SHALL pass through a 2-flop synchroniser before use, adding 2 cycles of lock latency.

Reset
REQ-027 rst SHALL force IDLE and reset outputs to: req_ready = 1, busy = 0, done = 0, err = 0, rd_valid = 0, rd_data = 0, wr_ready = 0, pll_mdopc = 00, pll_mdainc = 0, pll_mdwdi = 0, pll_reset = 0.
REQ-028 rst mid-burst SHALL abort with no further opcodes issued and no done pulse; rst during PRST SHALL deassert pll_reset in the next cycle.

Structure
REQ-029 Package pll_drp_pkg SHALL hold the opcode constants and the state enumeration.
REQ-030 The synchroniser SHALL be sub-module pll_lock_sync; everything else SHALL be a single FSM with a beat counter, a latency counter and a wait counter.

Verification
REQ-031 Write addr 0x10, len 0, relock 0, data 0xA5 -> opcode 11/0x10, then 01/0xA5 with mdainc 0, then done one cycle later.
REQ-032 Read addr 0x20, len 3, PLL model returning addr+1 -> rd_data 0x21..0x24; mdainc = 1,1,1,0; each rd_valid exactly RD_LAT cycles after its opcode.
REQ-033 Write len 1 with wr_valid held low 5 cycles -> NOP held for those cycles, then two write beats, one per wr_valid cycle.
REQ-034 Relock with lock rising 40 cycles after pll_reset falls -> pll_reset high for 16 cycles; done 2-3 cycles after lock rises; err = 0.
REQ-035 Relock with lock stuck at 0 and LOCK_TIMEOUT = 100 -> err = 1 and done after 100 cycles; the next accepted request clears err.
REQ-036 rst asserted during the third beat of a 4-beat read -> no further opcodes, no done pulse, req_ready = 1 the cycle after reset.

Source files
------------

// File: rtl/pll_drp_pkg.sv
// Shared opcode constants and controller state encoding for the PLL
// dynamic-reconfiguration port controller.
package pll_drp_pkg;

  localparam logic [1:0] OPC_NOP   = 2'b00;
  localparam logic [1:0] OPC_WRITE = 2'b01;
  localparam logic [1:0] OPC_READ  = 2'b10;
  localparam logic [1:0] OPC_ADDR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WBEAT,
    ST_RCMD,
    ST_RWAIT,
    ST_PRST,
    ST_WLOCK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the clk domain.
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic lock_in,
  output logic lock_out
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= lock_in;
      sync_p1 <= meta_p0;
    end
  end

  assign lock_out = sync_p1;

endmodule

// File: rtl/pll_drp_ctrl.sv
// Burst controller for the PLL register port: address load, write/read beats
// with auto-increment, and an optional PLL reset / lock-wait after the burst.
module pll_drp_ctrl
  import pll_drp_pkg::*;
#(
  parameter int RD_LAT       = 2,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [3:0] req_len,
  input  logic       req_relock,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] pll_mdopc,
  output logic       pll_mdainc,
  output logic [7:0] pll_mdwdi,
  input  logic [7:0] pll_mdrdo,
  output logic       pll_reset,
  input  logic       pll_lock
);

  localparam int WAIT_MAX = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int LAT_W    = $clog2(RD_LAT + 1);

  localparam logic [WAIT_W-1:0] RST_LAST  = WAIT_W'(RST_CYCLES - 1);
  localparam logic [WAIT_W-1:0] LOCK_LAST = WAIT_W'(LOCK_TIMEOUT - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT);

  state_t            state, state_d;
  logic [3:0]        beat_cnt, beat_d;
  logic [LAT_W-1:0]  lat_cnt, lat_d;
  logic [WAIT_W-1:0] wait_cnt, wait_d;
  logic              err_q, err_d;
  logic [7:0]        rd_data_q;
  logic              write_q, relock_q;
  logic [7:0]        addr_q;
  logic              lock_s;
  logic              accept;
  state_t            burst_exit;

  pll_lock_sync u_lock_sync (
    .clk      (clk),
    .rst      (rst),
    .lock_in  (pll_lock),
    .lock_out (lock_s)
  );

  assign accept     = req_ready & req_valid;
  assign burst_exit = relock_q ? ST_PRST : ST_DONE;

  always_comb begin
    state_d    = state;
    beat_d     = beat_cnt;
    lat_d      = '0;
    wait_d     = '0;
    err_d      = err_q;
    req_ready  = 1'b0;
    wr_ready   = 1'b0;
    rd_valid   = 1'b0;
    done       = 1'b0;
    pll_mdopc  = OPC_NOP;
    pll_mdainc = 1'b0;
    pll_mdwdi  = 8'h00;
    pll_reset  = 1'b0;

    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = ST_ADDR;
          beat_d  = req_len;
          err_d   = 1'b0;
        end
      end
      ST_ADDR: begin
        pll_mdopc = OPC_ADDR;
        pll_mdwdi = addr_q;
        state_d   = write_q ? ST_WBEAT : ST_RCMD;
      end
      ST_WBEAT: begin
        if (wr_valid) begin
          pll_mdopc  = OPC_WRITE;
          pll_mdwdi  = wr_data;
          wr_ready   = 1'b1;
          pll_mdainc = (beat_cnt != 4'd0);
          if (beat_cnt != 4'd0) beat_d = beat_cnt - 4'd1;
          else                  state_d = burst_exit;
        end
      end
      ST_RCMD: begin
        pll_mdopc  = OPC_READ;
        pll_mdainc = (beat_cnt != 4'd0);
        lat_d      = LAT_W'(1);
        state_d    = ST_RWAIT;
      end
      // lat_cnt counts cycles since the read opcode; data is taken on the last
      ST_RWAIT: begin
        if (lat_cnt == LAT_LAST) begin
          rd_valid = 1'b1;
          if (beat_cnt != 4'd0) begin
            beat_d  = beat_cnt - 4'd1;
            state_d = ST_RCMD;
          end else begin
            state_d = burst_exit;
          end
        end else begin
          lat_d = lat_cnt + LAT_W'(1);
        end
      end
      ST_PRST: begin
        pll_reset = 1'b1;
        if (wait_cnt == RST_LAST) state_d = ST_WLOCK;
        else                      wait_d  = wait_cnt + WAIT_W'(1);
      end
      ST_WLOCK: begin
        if (lock_s) begin
          state_d = ST_DONE;
        end else if (wait_cnt == LOCK_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_cnt + WAIT_W'(1);
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      beat_cnt  <= 4'd0;
      lat_cnt   <= '0;
      wait_cnt  <= '0;
      err_q     <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      state    <= state_d;
      beat_cnt <= beat_d;
      lat_cnt  <= lat_d;
      wait_cnt <= wait_d;
      err_q    <= err_d;
      if (rd_valid) rd_data_q <= pll_mdrdo;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      write_q  <= req_write;
      addr_q   <= req_addr;
      relock_q <= req_relock;
    end
  end

  // Read data is shown in the capture cycle itself, then held.
  assign rd_data = rd_valid ? pll_mdrdo : rd_data_q;
  assign busy    = (state != ST_IDLE);
  assign err     = err_q;

endmodule
